// File: rtl/int_addtree_pipe_if.sv
// Stream interface of the integer reduction tree: operand beats in, reduced results out.
interface int_addtree_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned OUT_W  = 32
);
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic                     acc_mode;
    logic [OUT_W-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_ovf;

    modport slave (
        input  in_data, in_valid, in_last, acc_mode, out_ready,
        output in_ready, out_data, out_valid, out_ovf
    );

    modport master (
        output in_data, in_valid, in_last, acc_mode, out_ready,
        input  in_ready, out_data, out_valid, out_ovf
    );
endinterface

// File: rtl/int_addtree_pipe.sv
// Fully pipelined signed reduction tree: input register, log2(NUM_IN) adder levels,
// then an accumulate/narrow register. One global advance enable stalls every stage.
module int_addtree_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned SAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    int_addtree_pipe_if.slave bus
);
    localparam int unsigned L     = $clog2(NUM_IN);
    localparam int unsigned SUM_W = DATA_W + L;
    localparam int unsigned ACC_W = DATA_W + L + 16;
    localparam int unsigned TOP_W = ACC_W - OUT_W + 1;

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                     adv;
    logic [L:0]               vld_q;
    logic [L:0]               last_q;
    logic [L:0]               mode_q;
    logic [NUM_IN*DATA_W-1:0] in_q;

    logic [SUM_W-1:0] tree_sum;
    logic [ACC_W-1:0] total;
    logic [TOP_W-1:0] total_top;
    logic             fits;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_ovf_q, out_ovf_d;

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv && rst_n;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ovf   = out_ovf_q;

    // Stage valids; bit 0 is the input register, bit j is adder level j.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[L-1:0], bus.in_valid};
        end
    end

    // Sideband and operands travel with the beat; they are only qualified by vld_q.
    always_ff @(posedge clk) begin
        if (adv) begin
            last_q <= {last_q[L-1:0], bus.in_last};
            mode_q <= {mode_q[L-1:0], bus.acc_mode};
            in_q   <= bus.in_data;
        end
    end

    // Level j pairs the DATA_W+j-1 bit terms of the level above into DATA_W+j bit sums.
    for (genvar j = 1; j <= L; j++) begin : g_lvl
        localparam int unsigned N  = NUM_IN >> j;
        localparam int unsigned W  = DATA_W + j;
        localparam int unsigned WP = W - 1;

        logic [2*N*WP-1:0] src;
        logic [N*W-1:0]    sum_d;
        logic [N*W-1:0]    sum_q;

        if (j == 1) begin : g_src_in
            assign src = in_q;
        end else begin : g_src_lvl
            assign src = g_lvl[j-1].sum_q;
        end

        always_comb begin
            sum_d = '0;
            for (int unsigned k = 0; k < N; k++) begin
                sum_d[k*W +: W] = W'($signed(src[2*k*WP +: WP]))
                                + W'($signed(src[(2*k+1)*WP +: WP]));
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                sum_q <= sum_d;
            end
        end
    end

    assign tree_sum = g_lvl[L].sum_q;

    // Exact result at accumulator width; the running total only joins in frame mode.
    always_comb begin
        total = ACC_W'($signed(tree_sum));
        if (mode_q[L]) begin
            total = total + acc_q;
        end
    end

    assign total_top = total[ACC_W-1:OUT_W-1];
    assign fits      = (&total_top) || !(|total_top);

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (vld_q[L]) begin
                if (mode_q[L] && !last_q[L]) begin
                    acc_d = total;
                end else begin
                    out_valid_d = 1'b1;
                    out_ovf_d   = !fits;
                    if (fits || (SAT == 0)) begin
                        out_data_d = total[OUT_W-1:0];
                    end else begin
                        out_data_d = total[ACC_W-1] ? OUT_MIN : OUT_MAX;
                    end
                end
                // Any last beat closes the frame, so a corrupted frame cannot leak forward.
                if (last_q[L]) begin
                    acc_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_int_addtree_pipe.sv
// Bench for int_addtree_pipe: a wrapping and a saturating instance share one stimulus
// stream and are checked every cycle against an arithmetic reference model.
module tb_int_addtree_pipe;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_IN = 8;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned BUS_W  = NUM_IN * DATA_W;

    typedef struct {
        logic [31:0] w;
        logic        wo;
        logic [31:0] s;
        logic        so;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [BUS_W-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             acc_mode = 1'b0;
    logic             out_ready = 1'b1;
    bit               rdy_rand = 1'b0;

    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  q[$];
    longint model_acc = 0;
    bit    rst_prev = 1'b0;

    always #5 clk = ~clk;

    int_addtree_pipe_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .OUT_W(OUT_W)) if_w ();
    int_addtree_pipe_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .OUT_W(OUT_W)) if_s ();

    assign if_w.in_data   = in_data;
    assign if_w.in_valid  = in_valid;
    assign if_w.in_last   = in_last;
    assign if_w.acc_mode  = acc_mode;
    assign if_w.out_ready = out_ready;
    assign if_s.in_data   = in_data;
    assign if_s.in_valid  = in_valid;
    assign if_s.in_last   = in_last;
    assign if_s.acc_mode  = acc_mode;
    assign if_s.out_ready = out_ready;

    int_addtree_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .OUT_W(OUT_W), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(if_w)
    );
    int_addtree_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .OUT_W(OUT_W), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint beat_sum(input logic [BUS_W-1:0] d);
        longint s = 0;
        for (int k = 0; k < NUM_IN; k++) s += longint'($signed(d[k*DATA_W +: DATA_W]));
        return s;
    endfunction

    // Reference narrowing straight from the representable OUT_W range.
    function automatic exp_t narrow(input longint v);
        exp_t   e;
        longint mx = (64'sd1 <<< (OUT_W - 1)) - 1;
        longint mn = -(64'sd1 <<< (OUT_W - 1));
        logic [63:0] bits = v;
        e.w  = bits[31:0];
        e.wo = (v > mx) || (v < mn);
        e.s  = (v > mx) ? 32'h7FFF_FFFF : (v < mn) ? 32'h8000_0000 : bits[31:0];
        e.so = e.wo;
        return e;
    endfunction

    function automatic logic [BUS_W-1:0] fill(input logic [31:0] v);
        logic [BUS_W-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*DATA_W +: DATA_W] = v;
        return d;
    endfunction

    function automatic logic [BUS_W-1:0] ramp();
        logic [BUS_W-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*DATA_W +: DATA_W] = 32'(k + 1);
        return d;
    endfunction

    // Model and compare process; every sample describes the upcoming rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_in_ready_w", 64'(if_w.in_ready), 64'd0);
            chk("rst_in_ready_s", 64'(if_s.in_ready), 64'd0);
            if (rst_prev) begin
                chk("rst_out_valid", 64'({if_w.out_valid, if_s.out_valid}), 64'd0);
                chk("rst_out_data", {if_w.out_data, if_s.out_data}, 64'd0);
                chk("rst_out_ovf", 64'({if_w.out_ovf, if_s.out_ovf}), 64'd0);
            end
            q.delete();
            model_acc = 0;
            rst_prev  = 1'b1;
        end else begin
            rst_prev = 1'b0;
            chk("in_ready_w", 64'(if_w.in_ready), 64'(!if_w.out_valid || out_ready));
            chk("in_ready_s", 64'(if_s.in_ready), 64'(!if_s.out_valid || out_ready));
            if (if_w.out_valid || if_s.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'({if_w.out_valid, if_s.out_valid}), 64'd0);
                end else begin
                    e = q[0];
                    chk("out_valid_w", 64'(if_w.out_valid), 64'd1);
                    chk("out_valid_s", 64'(if_s.out_valid), 64'd1);
                    chk("wrap_data", 64'(if_w.out_data), 64'(e.w));
                    chk("wrap_ovf", 64'(if_w.out_ovf), 64'(e.wo));
                    chk("sat_data", 64'(if_s.out_data), 64'(e.s));
                    chk("sat_ovf", 64'(if_s.out_ovf), 64'(e.so));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && if_w.in_ready) begin
                if (!acc_mode) begin
                    q.push_back(narrow(beat_sum(in_data)));
                end else begin
                    model_acc += beat_sum(in_data);
                    if (in_last) begin
                        q.push_back(narrow(model_acc));
                        model_acc = 0;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [BUS_W-1:0] d, input logic last, input logic mode);
        bit done = 1'b0;
        in_data  = d;
        in_last  = last;
        acc_mode = mode;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            done = if_w.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic single_check(input string nm, input logic [BUS_W-1:0] d, input logic last,
                                input logic mode, input logic [31:0] ew, input logic ewo,
                                input logic [31:0] es, input logic eso);
        int k = 0;
        send_beat(d, last, mode);
        in_valid = 1'b0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (if_w.out_valid) break;
        end
        chk({nm, "_latency"}, 64'(k), 64'd4);
        chk({nm, "_wrap_data"}, 64'(if_w.out_data), 64'(ew));
        chk({nm, "_wrap_ovf"}, 64'(if_w.out_ovf), 64'(ewo));
        chk({nm, "_sat_data"}, 64'(if_s.out_data), 64'(es));
        chk({nm, "_sat_ovf"}, 64'(if_s.out_ovf), 64'(eso));
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input string nm, input longint exp[$], input bit consec);
        int cyc = 0;
        int last_c = 0;
        int got = 0;
        logic [63:0] t;
        while (got < exp.size() && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (if_w.out_valid && out_ready) begin
                t = exp[got];
                chk({nm, "_data"}, 64'(if_w.out_data), 64'(t[31:0]));
                if (consec && got > 0) chk({nm, "_gap"}, 64'(cyc - last_c), 64'd1);
                last_c = cyc;
                got++;
            end
        end
        chk({nm, "_count"}, 64'(got), 64'(exp.size()));
    endtask

    task automatic stall_ctrl();
        int i = 0;
        while (!if_w.out_valid && i < 50) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(if_w.in_ready), 64'd0);
            chk("stall_hold_data", 64'(if_w.out_data), 64'd16);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint stream_exp[$];
        longint acc_exp[$];
        logic [BUS_W-1:0] d;
        logic [31:0] op;
        int nb;
        logic mode;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        single_check("ramp", ramp(), 1'b0, 1'b0, 32'd36, 1'b0, 32'd36, 1'b0);

        stream_exp = '{8, 16, 24, 32, 40, 48};
        fork
            begin
                for (int k = 1; k <= 6; k++) send_beat(fill(32'(k)), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            collect("stream", stream_exp, 1'b1);
        join
        idle(2);
        fork
            begin
                for (int k = 1; k <= 6; k++) send_beat(fill(32'(k)), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            collect("stall", stream_exp, 1'b0);
            stall_ctrl();
        join
        idle(2);

        acc_exp = '{-24, 16};
        fork
            begin
                send_beat(fill(32'hFFFF_FFFF), 1'b0, 1'b1);
                send_beat(fill(32'hFFFF_FFFF), 1'b0, 1'b1);
                send_beat(fill(32'hFFFF_FFFF), 1'b1, 1'b1);
                send_beat(fill(32'd2), 1'b1, 1'b1);
                in_valid = 1'b0;
            end
            collect("frame", acc_exp, 1'b0);
        join
        idle(2);

        single_check("posmax", fill(32'h7FFF_FFFF), 1'b0, 1'b0,
                     32'hFFFF_FFF8, 1'b1, 32'h7FFF_FFFF, 1'b1);
        single_check("negmax", fill(32'h8000_0000), 1'b0, 1'b0,
                     32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1);

        // Partial frame with beats still in the tree, then a one-cycle reset.
        send_beat(fill(32'd5), 1'b0, 1'b1);
        send_beat(fill(32'd5), 1'b0, 1'b1);
        idle(6);
        for (int k = 0; k < 3; k++) send_beat(fill(32'd3), 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 64'({if_w.out_valid, if_s.out_valid}), 64'd0);
        chk("mid_rst_out_data", {if_w.out_data, if_s.out_data}, 64'd0);
        rst_n = 1'b1;
        idle(8);
        single_check("post_rst", ramp(), 1'b1, 1'b1, 32'd36, 1'b0, 32'd36, 1'b0);

        rdy_rand = 1'b1;
        for (int f = 0; f < 120; f++) begin
            mode = 1'($urandom_range(0, 1));
            nb   = mode ? $urandom_range(1, 5) : 1;
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    case ($urandom_range(0, 7))
                        0:       op = 32'h7FFF_FFFF;
                        1:       op = 32'h8000_0000;
                        2:       op = 32'($urandom_range(0, 20)) - 32'd10;
                        default: op = $urandom;
                    endcase
                    d[k*DATA_W +: DATA_W] = op;
                end
                send_beat(d, mode ? (b == nb - 1) : 1'($urandom_range(0, 1)), mode);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        idle(1);
        for (int i = 0; i < 60 && q.size() != 0; i++) idle(1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
